// File: rtl/keccak_stream_driver.sv
// Host-side stream master for the Keccak core: streams in_len words from the
// input RAM onto din, then collects out_len dout words into the output RAM.
module keccak_stream_driver #(
    parameter int WIN   = 64,
    parameter int WOUT  = 64,
    parameter int AW    = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] in_len,
    input  logic [LEN_W-1:0] out_len,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIN-1:0]   rd_data,
    output logic             din_valid,
    input  logic             din_ready,
    output logic [WIN-1:0]   din,
    input  logic             dout_valid,
    output logic             dout_ready,
    input  logic [WOUT-1:0]  dout,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WOUT-1:0]  wr_data
);

    typedef enum logic [1:0] {IDLE, SEND, RECV, FIN} state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     in_len_q, in_len_d, out_len_q, out_len_d;
    logic [LEN_W-1:0]     rd_idx_q, rd_idx_d, sent_q, sent_d, rx_q, rx_d;
    logic                 pend_q, pend_d;
    logic [1:0][WIN-1:0]  fifo_q, fifo_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                 wr_en_q, wr_en_d, done_q, done_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [WOUT-1:0]      wr_data_q, wr_data_d;

    logic       in_send, fire, rx_fire, push, pop;
    logic [1:0] occ;
    logic [WIN-1:0] head;

    // A returning read bypasses the empty FIFO so the first word lands two cycles after start.
    always_comb begin
        in_send    = (state_q == SEND);
        occ        = cnt_q + {1'b0, pend_q};
        rd_en      = in_send && (occ < 2'd2) && (rd_idx_q < in_len_q);
        rd_addr    = rd_en ? AW'(rd_idx_q) : '0;
        head       = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : rd_data;
        din_valid  = in_send && ((cnt_q != 2'd0) || pend_q);
        din        = din_valid ? head : '0;
        fire       = din_valid && din_ready;
        dout_ready = (state_q == RECV) && (rx_q < out_len_q);
        rx_fire    = dout_ready && dout_valid;
        push       = pend_q && !(fire && (cnt_q == 2'd0));
        pop        = fire && (cnt_q != 2'd0);
        busy       = (state_q != IDLE);
        done       = done_q;
        wr_en      = wr_en_q;
        wr_addr    = wr_addr_q;
        wr_data    = wr_data_q;
    end

    always_comb begin
        state_d   = state_q;
        in_len_d  = in_len_q;
        out_len_d = out_len_q;
        rd_idx_d  = rd_en ? rd_idx_q + LEN_W'(1) : rd_idx_q;
        sent_d    = fire ? sent_q + LEN_W'(1) : sent_q;
        rx_d      = rx_q;
        pend_d    = rd_en;
        fifo_d    = fifo_q;
        cnt_d     = cnt_q + 2'(push) - 2'(pop);
        rd_ptr_d  = pop ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d  = push ? ~wr_ptr_q : wr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
        if (push) fifo_d[wr_ptr_q] = rd_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    in_len_d  = in_len;
                    out_len_d = out_len;
                    rd_idx_d  = '0;
                    sent_d    = '0;
                    rx_d      = '0;
                    cnt_d     = '0;
                    rd_ptr_d  = 1'b0;
                    wr_ptr_d  = 1'b0;
                    if (in_len != '0)       state_d = SEND;
                    else if (out_len != '0) state_d = RECV;
                    else                    state_d = FIN;
                end
            end
            SEND: begin
                if (fire && (sent_q == in_len_q - LEN_W'(1))) begin
                    state_d = (out_len_q != '0) ? RECV : FIN;
                end
            end
            RECV: begin
                if (rx_fire) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(rx_q);
                    wr_data_d = dout;
                    rx_d      = rx_q + LEN_W'(1);
                    if (rx_q == out_len_q - LEN_W'(1)) state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            in_len_q  <= '0;
            out_len_q <= '0;
            rd_idx_q  <= '0;
            sent_q    <= '0;
            rx_q      <= '0;
            pend_q    <= 1'b0;
            fifo_q    <= '0;
            cnt_q     <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_len_q  <= in_len_d;
            out_len_q <= out_len_d;
            rd_idx_q  <= rd_idx_d;
            sent_q    <= sent_d;
            rx_q      <= rx_d;
            pend_q    <= pend_d;
            fifo_q    <= fifo_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // The issue rule keeps buffered + outstanding <= 2, so a read never returns into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(pend_q && (cnt_q == 2'd2)));

endmodule

// File: tb/tb_keccak_stream_driver.sv
// Scoreboard bench for keccak_stream_driver: RAM and core models feed the DUT,
// expected din words and RAM writes are queued per job and popped by a monitor.
module tb_keccak_stream_driver;

    localparam int WIN = 64, WOUT = 64, AW = 8, LEN_W = 8;

    logic             clk, rst, start;
    logic [LEN_W-1:0] in_len, out_len;
    logic             busy, done, rd_en, din_valid, din_ready, dout_valid, dout_ready, wr_en;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [WIN-1:0]   rd_data, din;
    logic [WOUT-1:0]  dout, wr_data;

    keccak_stream_driver #(.WIN(WIN), .WOUT(WOUT), .AW(AW), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_len(in_len), .out_len(out_len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIN-1:0]     ram [256];
    logic [WOUT-1:0]    core_q [$];
    logic [WIN-1:0]     exp_din [$];
    logic [AW+WOUT-1:0] exp_wr [$];
    logic [WOUT-1:0]    junk;
    int tests = 0, fails = 0, cyc = 0, ready_mode = 0;
    int xfer_cnt, rd_cnt, wr_cnt, done_cnt, first_din_cyc, first_rdy_cyc, last_xfer_cyc;
    int done_cyc, start_cyc, job_in_len;
    logic prev_stall;
    logic [WIN-1:0] prev_din;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Input RAM with one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // Core side: pops a dout word on handshake, presents next word and din_ready pattern.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && dout_valid && dout_ready && core_q.size() != 0) junk = core_q.pop_front();
        #1;
        dout_valid = (core_q.size() != 0);
        dout       = dout_valid ? core_q[0] : '0;
        din_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Monitor: compares every DUT transfer and write against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_ready) begin
                checkOutput("dout_ready_before_send_done", 128'(xfer_cnt >= job_in_len), 128'(1));
                if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
            end
            if (rd_en) begin
                checkOutput("rd_addr", 128'(rd_addr), 128'(rd_cnt));
                checkOutput("rd_occupancy", 128'((rd_cnt - xfer_cnt) < 2), 128'(1));
                rd_cnt++;
            end
            if (prev_stall) checkOutput("din_hold", {din_valid, din}, {1'b1, prev_din});
            if (din_valid && first_din_cyc < 0) first_din_cyc = cyc;
            if (din_valid && din_ready) begin
                if (exp_din.size() == 0) checkOutput("din_extra", 128'(1), 128'(0));
                else checkOutput("din_data", din, exp_din.pop_front());
                last_xfer_cyc = cyc;
                xfer_cnt++;
            end
            prev_stall = din_valid && !din_ready;
            prev_din   = din;
            if (wr_en) begin
                if (exp_wr.size() == 0) checkOutput("wr_extra", 128'(1), 128'(0));
                else checkOutput("wr_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checkOutput("busy_at_done", 128'(busy), 128'(0));
            end
        end
    end

    task automatic checkReset();
        checkOutput("reset_ctrl", {busy, done, rd_en, din_valid, dout_ready, wr_en, rd_addr, wr_addr}, '0);
        checkOutput("reset_din", din, '0);
        checkOutput("reset_wr_data", wr_data, '0);
    endtask

    task automatic prepJob(input int n_in, input int n_out, input logic [WOUT-1:0] base, input int mode);
        exp_din.delete(); exp_wr.delete(); core_q.delete();
        for (int i = 0; i < n_in; i++) exp_din.push_back(ram[i]);
        for (int i = 0; i < n_out; i++) begin
            core_q.push_back(base + WOUT'(i));
            exp_wr.push_back({AW'(i), base + WOUT'(i)});
        end
        xfer_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        first_din_cyc = -1; first_rdy_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
        prev_stall = 1'b0; job_in_len = n_in; ready_mode = mode;
        @(posedge clk); #1;
        start = 1'b1; in_len = LEN_W'(n_in); out_len = LEN_W'(n_out); start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int n_in, input int n_out, input logic [WOUT-1:0] base,
                                 input int mode, input int restart_at);
        prepJob(n_in, n_out, base, mode);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
            @(posedge clk);
            if (restart_at > 0 && k == restart_at) begin
                #1; start = 1'b1; in_len = 8'd3; out_len = 8'd1;
                @(posedge clk); #1; start = 1'b0;
            end
        end
        if (done_cnt == 0) checkOutput("done_timeout", 128'(0), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("xfer_count", 128'(xfer_cnt), 128'(n_in));
        checkOutput("rd_count", 128'(rd_cnt), 128'(n_in));
        checkOutput("wr_count", 128'(wr_cnt), 128'(n_out));
        checkOutput("done_count", 128'(done_cnt), 128'(1));
        checkOutput("busy_idle", 128'(busy), 128'(0));
        checkOutput("exp_din_left", 128'(exp_din.size()), 128'(0));
        checkOutput("exp_wr_left", 128'(exp_wr.size()), 128'(0));
        if (n_in > 0) checkOutput("first_din_latency", 128'(first_din_cyc - start_cyc), 128'(2));
        if (n_in > 0 && mode == 0) checkOutput("throughput", 128'(last_xfer_cyc - first_din_cyc), 128'(n_in - 1));
        if (n_in == 0 && n_out > 0) checkOutput("dout_ready_latency", 128'(first_rdy_cyc - start_cyc), 128'(1));
        if (n_in == 0 && n_out == 0) checkOutput("done_latency", 128'(done_cyc - start_cyc), 128'(2));
        if (n_in == 3 && n_out == 2 && mode == 0) checkOutput("basic_done_cycle", 128'(done_cyc - start_cyc), 128'(8));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_len = '0; out_len = '0;
        din_ready = 1'b0; dout_valid = 1'b0; dout = '0;
        for (int i = 0; i < 256; i++) ram[i] = 64'hA0 + 64'(i);
        #12;
        checkReset();
        @(negedge clk); rst = 1'b0;

        applyStimulus(3, 2, 64'hB0, 0, 0);
        applyStimulus(4, 1, 64'hE0, 1, 0);
        applyStimulus(0, 2, 64'hB8, 0, 0);
        applyStimulus(2, 0, 64'h0, 0, 0);
        applyStimulus(0, 0, 64'h0, 0, 0);
        applyStimulus(3, 1, 64'hC0, 0, 0);
        applyStimulus(255, 255, 64'h100, 1, 100);

        prepJob(10, 2, 64'hF0, 0);
        for (int k = 0; k < 100 && xfer_cnt < 5; k++) @(posedge clk);
        checkOutput("reached_mid_send", 128'(xfer_cnt >= 5), 128'(1));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkReset();
        exp_din.delete(); exp_wr.delete(); core_q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_done_after_reset", 128'(done_cnt), 128'(0));
        applyStimulus(1, 1, 64'hD0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
